// File: rtl/alu_exec_unit_if.sv
// ============================================================================
// Module   : alu_exec_unit_if
// Brief    : Request/response bundle between the ID/EX stage and alu_exec_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic [3:0]       alu_ctrl_i;
  logic             alu_src1_i;
  logic             jump_type_i;
  logic [4:0]       shamt_i;
  logic [WIDTH-1:0] rs_data_i;
  logic [WIDTH-1:0] src2_i;

  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             branch_o;
  logic             jump_o;
  logic             illegal_o;
  logic             stall_o;

  modport master (
    output valid_i, alu_ctrl_i, alu_src1_i, jump_type_i, shamt_i, rs_data_i, src2_i,
    input  ready_o, valid_o, result_o, zero_o, branch_o, jump_o, illegal_o, stall_o
  );

  modport slave (
    input  valid_i, alu_ctrl_i, alu_src1_i, jump_type_i, shamt_i, rs_data_i, src2_i,
    output ready_o, valid_o, result_o, zero_o, branch_o, jump_o, illegal_o, stall_o
  );
endinterface

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Execute-stage ALU, single-cycle ops plus iterative shift-add MUL.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  wire                 clk_i,
  input  wire                 rst_i,
  alu_exec_unit_if.slave      bus
);

  localparam int         CNT_W    = $clog2(WIDTH);
  localparam logic [3:0] CODE_MUL = 4'b0101;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mul_jump_q, mul_jump_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               branch_q, branch_d;
  logic               jump_q, jump_d;
  logic               illegal_q, illegal_d;

  logic [WIDTH-1:0]   op_a, op_b, op_diff, op_res, acc_next;
  logic               op_branch, op_illegal;

  // Single-cycle datapath
  always_comb begin
    op_a       = bus.alu_src1_i ? {{(WIDTH-5){1'b0}}, bus.shamt_i} : bus.rs_data_i;
    op_b       = bus.src2_i;
    op_diff    = op_a - op_b;
    op_res     = '0;
    op_branch  = 1'b0;
    op_illegal = 1'b0;
    case (bus.alu_ctrl_i)
      4'b0000: op_res = op_a & op_b;
      4'b0001: op_res = op_a | op_b;
      4'b0010: op_res = op_a + op_b;
      4'b0011: op_res = op_b << op_a[4:0];
      4'b0100: op_res = op_b << 16;
      4'b0101: op_res = '0;
      4'b0110: begin
        op_res    = op_diff;
        op_branch = (op_a == op_b);
      end
      4'b0111: op_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b1000: op_res = bus.rs_data_i;
      4'b1110: begin
        op_res    = op_diff;
        op_branch = (op_a != op_b);
      end
      4'b1111: op_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      default: op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    mul_jump_d = mul_jump_q;
    valid_d    = 1'b0;
    result_d   = result_q;
    zero_d     = zero_q;
    branch_d   = branch_q;
    jump_d     = jump_q;
    illegal_d  = illegal_q;
    acc_next   = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          if (bus.alu_ctrl_i == CODE_MUL) begin
            mcand_d    = op_a;
            mplier_d   = op_b;
            acc_d      = '0;
            cnt_d      = '0;
            mul_jump_d = bus.jump_type_i;
            state_d    = MUL_RUN;
          end else begin
            result_d  = op_res;
            zero_d    = (op_res == '0);
            branch_d  = op_branch;
            jump_d    = bus.jump_type_i;
            illegal_d = op_illegal;
            valid_d   = 1'b1;
          end
        end
      end
      MUL_RUN: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // The WIDTH-th iteration retires directly into the result register
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          result_d  = acc_next;
          zero_d    = (acc_next == '0);
          branch_d  = 1'b0;
          jump_d    = mul_jump_q;
          illegal_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      mul_jump_q <= 1'b0;
      valid_q    <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      branch_q   <= 1'b0;
      jump_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      mul_jump_q <= mul_jump_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      branch_q   <= branch_d;
      jump_q     <= jump_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.ready_o   = (state_q == IDLE);
  assign bus.stall_o   = (state_q != IDLE);
  assign bus.valid_o   = valid_q;
  assign bus.result_o  = result_q;
  assign bus.zero_o    = zero_q;
  assign bus.branch_o  = branch_q;
  assign bus.jump_o    = jump_q;
  assign bus.illegal_o = illegal_q;

endmodule

`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage consumer of the 4-bit ALU control code, the src1 select and the jump-type flag produced by the ALU control decoder.
- Performs single-cycle logic, arithmetic and shift operations with a registered result.
- Performs MUL as an iterative shift-add over WIDTH cycles and holds off the pipeline through a ready/valid handshake.
- Sits between the ID/EX pipeline register and the EX/MEM register; its busy indication drives the pipeline stall.

Parameters:
- WIDTH, 32, datapath width in bits; also the number of MUL iterations.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  operation request; accepted only when ready_o=1.
- alu_ctrl_i  in  4  ALU control code.
- alu_src1_i  in  1  1: src1 operand = shamt_i zero-extended; 0: src1 operand = rs_data_i.
- jump_type_i  in  1  1: JR request; result is the jump target.
- shamt_i  in  5  shift amount field.
- rs_data_i  in  WIDTH  first register operand.
- src2_i  in  WIDTH  second operand (rt or immediate, already muxed).
- ready_o  out  1  unit can accept an operation this cycle.
- valid_o  out  1  one-cycle pulse; result_o and the flags are valid.
- result_o  out  WIDTH  operation result.
- zero_o  out  1  result_o == 0.
- branch_o  out  1  branch condition met.
- jump_o  out  1  registered copy of jump_type_i for the completed operation.
- illegal_o  out  1  the completed operation used an unassigned code.
- stall_o  out  1  equals ~ready_o; drives the pipeline stall.

Behaviour:
- Reset values: ready_o=1; valid_o, result_o, zero_o, branch_o, jump_o, illegal_o = 0; state IDLE; multiplier registers cleared.
- Reset asserted mid-MUL aborts the operation; no valid_o is produced for it.
- Operand selection: A = alu_src1_i ? {0, shamt_i} : rs_data_i; B = src2_i.
- Code map, result and branch_o:
  - 0000 AND: A&B.
  - 0001 OR: A|B.
  - 0010 ADD: A+B, wraps mod 2^WIDTH, no overflow flag.
  - 0011 SLL/SLLV: B << A[4:0].
  - 0100 LUI: B << 16.
  - 0101 MUL: low WIDTH bits of A*B (same result signed or unsigned).
  - 0110 SUB/BEQ: A-B; branch_o = (A==B).
  - 0111 SLT: signed A<B gives 1, else 0.
  - 1000 JR: result = A (rs_data_i).
  - 1110 BNE: A-B; branch_o = (A!=B).
  - 1111 SLTU: unsigned A<B gives 1, else 0.
  - Any other code: result = 0, illegal_o=1.
- branch_o is 0 for every code except 0110 and 1110.
- FSM states: IDLE, MUL_RUN.
- IDLE:
  - valid_i & non-MUL code: register result and flags; valid_o=1 on the next cycle (latency 1). Back-to-back operations give one result per cycle.
  - valid_i & code 0101: latch A into the multiplicand register and B into the multiplier register; clear the accumulator and the iteration counter; ready_o goes low the next cycle; go to MUL_RUN. valid_o stays 0.
- MUL_RUN, each cycle:
  - if multiplier[0], add the multiplicand into the accumulator;
  - multiplicand <<= 1; multiplier >>= 1; counter += 1.
  - When counter reaches WIDTH-1 (the WIDTH-th iteration), the final accumulator is registered to result_o, valid_o=1 the next cycle, the state returns to IDLE and ready_o=1 in the same cycle as valid_o.
  - MUL latency: valid_o WIDTH+1 cycles after the accept edge.
- valid_i while ready_o=0 is ignored. The inputs need not be held after acceptance; all operands are latched at the accept edge.
- valid_o is 0 on every cycle without a completing operation; result_o and the flags hold their last value when valid_o=0.
- jump_o, zero_o, branch_o and illegal_o describe the same completed operation as result_o.
- MUL with either operand 0 still takes the full WIDTH cycles; no early termination.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles -> ready_o=1, valid_o=0, result_o=0; hold rst_i=0 with valid_i=0 for 10 cycles -> valid_o stays 0.
- Back-to-back single-cycle ops (one per cycle, rs_data_i=7, src2_i=5):
  - ADD 0010 -> valid_o with 12 on the next cycle;
  - SUB 0110 -> 2;
  - SLT 0111 with A=0xFFFFFFFF, B=1 -> 1;
  - SLTU 1111 with the same operands -> 0;
  - results appear on consecutive cycles.
- Shift and LUI:
  - SLL with alu_src1_i=1, shamt_i=4, src2_i=0x3 -> 0x30;
  - SLLV with rs_data_i=0x24, src2_i=1 -> 0x10 (uses only A[4:0]=4);
  - LUI with src2_i=0x1234 -> 0x12340000.
- MUL: rs_data_i=0x10001, src2_i=0x10003 at cycle t:
  - ready_o=0 over t+1..t+32;
  - valid_o=1 at t+33 with result 0x40003 (low 32 bits);
  - valid_i pulses during the busy window are ignored.
  - Also 0xFFFFFFFF * 0xFFFFFFFF -> 1.
- Branch and jump:
  - code 0110 with A=B=9 -> branch_o=1, zero_o=1;
  - code 1110 with A=9, B=8 -> branch_o=1, result_o=1;
  - JR 1000 with jump_type_i=1, rs_data_i=0x400 -> result_o=0x400, jump_o=1;
  - code 1001 -> illegal_o=1, result_o=0.
- Reset mid-MUL: start a MUL, assert rst_i at the 10th busy cycle -> next cycle ready_o=1, valid_o=0, and no later valid_o for the aborted MUL; then an ADD 1+1 -> result 2 one cycle after accept.
